// File: rtl/display_scheduler_if.sv
// rtl/display_scheduler_if.sv - source/display signal bundle for the display scheduler
interface display_scheduler_if;
  // requests from the time-keeping, alarm, stopwatch and minigame blocks
  logic        clock_set;
  logic        alarm_set;
  logic        stop_watch;
  logic        alarm_ringing;
  logic        minigame_enable;
  logic [1:0]  location;
  logic [1:0]  alarm_location;
  logic [15:0] cur_time;
  logic [15:0] alarm_time;
  logic [15:0] sw_time;
  logic [15:0] game_digits;
  // per-digit drive toward the segment output stage
  logic [3:0]  AN;
  logic [3:0]  BCD;
  logic        BLANK;
  logic        DP;
  logic [2:0]  mode;
  logic        mode_changed;

  // sources side: drives requests and data, observes the display
  modport master (
    output clock_set, alarm_set, stop_watch, alarm_ringing, minigame_enable,
    output location, alarm_location, cur_time, alarm_time, sw_time, game_digits,
    input  AN, BCD, BLANK, DP, mode, mode_changed
  );

  // scheduler side
  modport slave (
    input  clock_set, alarm_set, stop_watch, alarm_ringing, minigame_enable,
    input  location, alarm_location, cur_time, alarm_time, sw_time, game_digits,
    output AN, BCD, BLANK, DP, mode, mode_changed
  );
endinterface

// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - 4-digit display arbitration, digit scan, blink and DP policy
module display_scheduler #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 50000000
) (
  input logic                MCLK,
  input logic                RESET,
  display_scheduler_if.slave dif
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  localparam logic [2:0] MODE_CLOCK = 3'd0;
  localparam logic [2:0] MODE_SW    = 3'd1;
  localparam logic [2:0] MODE_ASET  = 3'd2;
  localparam logic [2:0] MODE_CSET  = 3'd3;
  localparam logic [2:0] MODE_RING  = 3'd4;
  localparam logic [2:0] MODE_GAME  = 3'd5;

  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic [2:0]         mode_q;

  logic [2:0]  req;
  logic        slot_end;
  logic        frame_end;
  logic        switch_now;
  logic [15:0] src;
  logic [3:0]  nibble;
  logic        blank_next;
  logic        dp_next;

  // fixed-priority request; CLOCK when nothing is asserted
  always_comb begin
    req = MODE_CLOCK;
    if (dif.minigame_enable)    req = MODE_GAME;
    else if (dif.alarm_ringing) req = MODE_RING;
    else if (dif.clock_set)     req = MODE_CSET;
    else if (dif.alarm_set)     req = MODE_ASET;
    else if (dif.stop_watch)    req = MODE_SW;
  end

  // mode only moves on the last cycle of digit 3 so a frame is never mixed
  always_comb begin
    slot_end   = (scan_cnt == SCAN_LAST);
    frame_end  = slot_end && (idx == 2'd3);
    switch_now = frame_end && (req != mode_q);
  end

  // live source data for the current owner and the nibble of the active digit
  always_comb begin
    case (mode_q)
      MODE_ASET: src = dif.alarm_time;
      MODE_SW:   src = dif.sw_time;
      MODE_GAME: src = dif.game_digits;
      default:   src = dif.cur_time;
    endcase
    case (idx)
      2'd0:    nibble = src[3:0];
      2'd1:    nibble = src[7:4];
      2'd2:    nibble = src[11:8];
      default: nibble = src[15:12];
    endcase
  end

  // blanking: cursor blink in set modes, whole-display blink while ringing,
  // and suppression of non-decimal nibbles except for raw minigame digits
  always_comb begin
    blank_next = 1'b0;
    if ((mode_q != MODE_GAME) && (nibble > 4'd9))
      blank_next = 1'b1;
    if ((mode_q == MODE_CSET) && (idx == dif.location) && blink_phase)
      blank_next = 1'b1;
    if ((mode_q == MODE_ASET) && (idx == dif.alarm_location) && blink_phase)
      blank_next = 1'b1;
    if ((mode_q == MODE_RING) && blink_phase)
      blank_next = 1'b1;
    dp_next = (idx == 2'd2) && (mode_q != MODE_GAME);
  end

  // digit-slot counter and digit index
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
    end else if (slot_end) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // display owner, loaded at frame boundaries, with a change pulse
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      mode_q           <= MODE_CLOCK;
      dif.mode_changed <= 1'b0;
    end else begin
      dif.mode_changed <= switch_now;
      if (frame_end)
        mode_q <= req;
    end
  end

  // blink timer; a new owner always starts in the visible phase
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (switch_now) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  // registered digit outputs, one cycle behind idx/mode/source data
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      dif.AN    <= 4'b1111;
      dif.BCD   <= 4'd0;
      dif.BLANK <= 1'b1;
      dif.DP    <= 1'b0;
    end else begin
      dif.AN    <= ~(4'b0001 << idx);
      dif.BCD   <= nibble;
      dif.BLANK <= blank_next;
      dif.DP    <= dp_next;
    end
  end

  assign dif.mode = mode_q;

endmodule
